// File: rtl/light_seq_checker_pkg.sv
// Shared definitions for the light-sequence checker.
// Holds the four legal generator patterns, the checker state encoding,
// the fault cause codes and a saturating dwell increment helper.
package light_seq_checker_pkg;

  // Legal generator patterns, written as {z,y,x}
  localparam logic [2:0] PAT_A = 3'b100;
  localparam logic [2:0] PAT_B = 3'b110;
  localparam logic [2:0] PAT_C = 3'b111;
  localparam logic [2:0] PAT_D = 3'b001;

  // Checker state
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Fault cause codes
  localparam logic [2:0] FC_NONE          = 3'd0;
  localparam logic [2:0] FC_ILLEGAL_CODE  = 3'd1;
  localparam logic [2:0] FC_ILLEGAL_TRANS = 3'd2;
  localparam logic [2:0] FC_OVERRUN       = 3'd3;
  localparam logic [2:0] FC_UNDERRUN      = 3'd4;

  localparam logic [2:0] DWELL_MAX = 3'd7;

  // Dwell after one more sample: restart at 1 on a pattern change,
  // otherwise count up and stick at DWELL_MAX.
  function automatic logic [2:0] dwell_next(input logic [2:0] dwell,
                                            input logic       same);
    if (!same)                   return 3'd1;
    else if (dwell == DWELL_MAX) return DWELL_MAX;
    else                         return dwell + 3'd1;
  endfunction

endpackage

// File: rtl/light_seq_decode.sv
// Purely combinational pattern decoder.
// Ports:
//   prev        previous registered pattern {z,y,x}
//   cur         current registered pattern {z,y,x}
//   legal       cur is one of the four legal patterns
//   phase       phase index of cur (0=A,1=B,2=C,3=D; 0 when illegal)
//   trans_legal prev->cur is an allowed step of the sequence
module light_seq_decode
  import light_seq_checker_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] cur,
  output logic       legal,
  output logic [1:0] phase,
  output logic       trans_legal
);

  always_comb begin
    legal = 1'b1;
    phase = 2'd0;
    case (cur)
      PAT_A:   phase = 2'd0;
      PAT_B:   phase = 2'd1;
      PAT_C:   phase = 2'd2;
      PAT_D:   phase = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // Only A and D may be held; every other step moves strictly forward.
  always_comb begin
    trans_legal = ((prev == PAT_A) && ((cur == PAT_A) || (cur == PAT_B))) ||
                  ((prev == PAT_B) &&  (cur == PAT_C))                    ||
                  ((prev == PAT_C) &&  (cur == PAT_D))                    ||
                  ((prev == PAT_D) && ((cur == PAT_D) || (cur == PAT_A)));
  end

endmodule

// File: rtl/light_seq_checker.sv
// Downstream monitor for the 3-bit light-sequence generator.
// Registers {z,y,x} once, locks onto the legal A,B,C,D sequence at the
// first A->B step, then checks every transition and dwell length. The
// first fault is latched with its cause until reset.
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   x, y, z     generator bits 0, 1, 2
//   locked      checker is tracking the sequence
//   phase       current pattern: 0=A 100, 1=B 110, 2=C 111, 3=D 001
//   period_cnt  completed periods since lock, saturating
//   fault       sticky fault flag
//   fault_code  0 none, 1 illegal code, 2 illegal transition,
//               3 dwell overrun, 4 dwell underrun
module light_seq_checker
  import light_seq_checker_pkg::*;
#(
  parameter int DWELL_A = 3,
  parameter int DWELL_D = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] period_cnt,
  output logic             fault,
  output logic [2:0]       fault_code
);

  localparam logic [2:0] LIM_A = 3'(DWELL_A);
  localparam logic [2:0] LIM_D = 3'(DWELL_D);

  // Registered input, the sample before it, and how long that earlier
  // sample's pattern had been held.
  logic [2:0]       p_q;
  logic [2:0]       prev_q;
  logic [2:0]       dwell_q;
  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;

  logic       cur_legal;
  logic [1:0] cur_phase;
  logic       trans_ok;
  logic [2:0] dwell_cur;
  logic       step_ab;
  logic       step_da;
  logic       overrun;
  logic       underrun;

  light_seq_decode u_decode (
    .prev        (prev_q),
    .cur         (p_q),
    .legal       (cur_legal),
    .phase       (cur_phase),
    .trans_legal (trans_ok)
  );

  // dwell_cur includes the p_q sample; dwell_q is the completed run of
  // prev_q, which is what the underrun check needs on a pattern change.
  always_comb begin
    dwell_cur = dwell_next(dwell_q, p_q == prev_q);
    step_ab   = (prev_q == PAT_A) && (p_q == PAT_B);
    step_da   = (prev_q == PAT_D) && (p_q == PAT_A);
    overrun   = ((p_q == PAT_A) && (dwell_cur > LIM_A)) ||
                ((p_q == PAT_D) && (dwell_cur > LIM_D)) ||
                (((p_q == PAT_B) || (p_q == PAT_C)) && (dwell_cur > 3'd1));
    underrun  = (step_ab && (dwell_q < LIM_A)) ||
                (step_da && (dwell_q < LIM_D));
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      ST_SYNC: begin
        if (!cur_legal) begin
          state_d = ST_FAULT;
          code_d  = FC_ILLEGAL_CODE;
        end else if (step_ab) begin
          state_d = ST_TRACK;
          phase_d = cur_phase;
        end
      end
      ST_TRACK: begin
        // Priority order decides which single cause is recorded.
        if (!cur_legal) begin
          state_d = ST_FAULT;
          code_d  = FC_ILLEGAL_CODE;
        end else if (!trans_ok) begin
          state_d = ST_FAULT;
          code_d  = FC_ILLEGAL_TRANS;
        end else if (overrun) begin
          state_d = ST_FAULT;
          code_d  = FC_OVERRUN;
        end else if (underrun) begin
          state_d = ST_FAULT;
          code_d  = FC_UNDERRUN;
        end else begin
          phase_d = cur_phase;
          if (step_ab && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        // Everything frozen until reset.
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q     <= PAT_A;
      prev_q  <= PAT_A;
      dwell_q <= 3'd0;
      state_q <= ST_SYNC;
      phase_q <= 2'd0;
      cnt_q   <= '0;
      code_q  <= FC_NONE;
    end else begin
      p_q     <= {z, y, x};
      prev_q  <= p_q;
      dwell_q <= dwell_cur;
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  assign locked     = (state_q == ST_TRACK);
  assign fault      = (state_q == ST_FAULT);
  assign phase      = phase_q;
  assign period_cnt = cnt_q;
  assign fault_code = code_q;

endmodule
